// File: rtl/fb_write_scheduler_pkg.sv
// Shared types and constants for the frame-buffer write scheduler.
// The x/y raster walk and the write pipeline are sized from these.
package fb_sched_pkg;
    localparam int H_PIX_DEF = 800;
    localparam int V_PIX_DEF = 600;
    localparam int ADDR_W    = 19;
    localparam int COORD_W   = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNAP  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_FLUSH = 2'd3
    } fb_state_t;
endpackage

// File: rtl/fb_write_scheduler_if.sv
// Bundle between the game logic and the frame-buffer write scheduler.
// The game side raises one-cycle request pulses and never sees back-pressure.
interface fb_write_scheduler_if;
    import fb_sched_pkg::*;

    // tick_req/clear_req are single-cycle pulses with no ready: the scheduler
    // always accepts them, coalescing repeats. wen qualifies addr_w each cycle.
    logic               tick_req;
    logic               clear_req;
    logic               halt;
    logic [COORD_W-1:0] x_m;
    logic [COORD_W-1:0] y_m;
    logic               src;
    logic [ADDR_W-1:0]  addr_w;
    logic               wen;
    logic               snap;
    logic               busy;
    logic               frame_done;

    modport master (
        input  tick_req, clear_req, halt,
        output x_m, y_m, src, addr_w, wen, snap, busy, frame_done
    );

    modport slave (
        output tick_req, clear_req, halt,
        input  x_m, y_m, src, addr_w, wen, snap, busy, frame_done
    );
endinterface

// File: rtl/fb_write_scheduler_raster_counter.sv
// Raster x/y walker: x runs fastest, y steps on each x wrap.
// 'last' flags the final pixel of the frame.
module raster_counter
    import fb_sched_pkg::*;
#(
    parameter int H_PIX = H_PIX_DEF,
    parameter int V_PIX = V_PIX_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);
    logic x_end;
    logic y_end;

    assign x_end = (x == COORD_W'(H_PIX - 1));
    assign y_end = (y == COORD_W'(V_PIX - 1));
    assign last  = x_end && y_end;

    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fb_write_scheduler.sv
// Schedules render and clear sweeps over the frame buffer, emitting raster
// coordinates and, PIPE cycles later, the matching write address/enable.
module fb_write_scheduler
    import fb_sched_pkg::*;
#(
    parameter int H_PIX = H_PIX_DEF,
    parameter int V_PIX = V_PIX_DEF,
    parameter int PIPE  = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    fb_write_scheduler_if.master bus,
    output fb_state_t            state_dbg
);
    if (H_PIX * V_PIX > (1 << ADDR_W)) begin : g_addr_overflow
        $error("fb_write_scheduler: H_PIX*V_PIX does not fit in ADDR_W bits");
    end
    if (PIPE < 1 || PIPE > 3) begin : g_bad_pipe
        $error("fb_write_scheduler: PIPE must be in 1..3");
    end

    fb_state_t          state, state_n;
    logic               pending_tick, pending_clear;
    logic               tick_any, clear_any;
    logic               grant_tick, grant_clear;
    logic [1:0]         flush_cnt;
    logic               flush_last;
    logic               src_q;
    logic               frame_done_q;
    logic               coord_valid;
    logic [COORD_W-1:0] rc_x, rc_y;
    logic               rc_last;
    logic [ADDR_W-1:0]  coord_addr;
    logic [PIPE-1:0]    wen_pipe;
    logic [ADDR_W-1:0]  addr_pipe [PIPE];

    // A pulse arriving in the same cycle as an IDLE grant is seen directly.
    assign tick_any    = pending_tick | bus.tick_req;
    assign clear_any   = pending_clear | bus.clear_req;
    assign flush_last  = (flush_cnt == 2'(PIPE - 1));
    assign coord_valid = (state == ST_SWEEP);
    assign coord_addr  = ADDR_W'(rc_y) * ADDR_W'(H_PIX) + ADDR_W'(rc_x);

    raster_counter #(.H_PIX(H_PIX), .V_PIX(V_PIX)) u_raster (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (grant_tick | grant_clear),
        .advance (coord_valid),
        .x       (rc_x),
        .y       (rc_y),
        .last    (rc_last)
    );

    always_comb begin
        state_n     = state;
        grant_tick  = 1'b0;
        grant_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clear_any) begin
                    grant_clear = 1'b1;
                    state_n     = ST_SNAP;
                end else if (tick_any && !bus.halt) begin
                    grant_tick = 1'b1;
                    state_n    = ST_SNAP;
                end
            end
            ST_SNAP:  state_n = ST_SWEEP;
            ST_SWEEP: if (rc_last) state_n = ST_FLUSH;
            ST_FLUSH: if (flush_last) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= ST_IDLE;
            pending_tick  <= 1'b0;
            pending_clear <= 1'b0;
            flush_cnt     <= 2'd0;
            src_q         <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state         <= state_n;
            pending_tick  <= tick_any & ~grant_tick;
            pending_clear <= clear_any & ~grant_clear;
            flush_cnt     <= (state == ST_FLUSH) ? flush_cnt + 2'd1 : 2'd0;
            if (grant_tick || grant_clear) src_q <= grant_clear;
            frame_done_q  <= (state == ST_FLUSH) && flush_last;
        end
    end

    // Write-phase delay line matching the colour pipeline depth.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wen_pipe <= '0;
            for (int i = 0; i < PIPE; i++) addr_pipe[i] <= '0;
        end else begin
            wen_pipe[0]  <= coord_valid;
            addr_pipe[0] <= coord_addr;
            for (int i = 1; i < PIPE; i++) begin
                wen_pipe[i]  <= wen_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    assign bus.x_m        = rc_x;
    assign bus.y_m        = rc_y;
    assign bus.src        = src_q;
    assign bus.addr_w     = addr_pipe[PIPE-1];
    assign bus.wen        = wen_pipe[PIPE-1];
    assign bus.snap       = (state == ST_SNAP) && !src_q;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.frame_done = frame_done_q;
    assign state_dbg      = state;
endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler: two instances (PIPE=1 and PIPE=3) on a 4x3
// raster, checked every cycle against a job-timeline model plus scenario checks.
module tb_fb_write_scheduler;
    import fb_sched_pkg::*;

    localparam int H = 4;
    localparam int V = 3;
    localparam int N = H * V;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        src;
        logic [18:0] addr;
        logic        wen;
        logic        snap;
        logic        busy;
        logic        done;
        fb_state_t   st;
    } obs_t;

    logic      CLK = 1'b0;
    logic      RESET;
    fb_state_t st0, st1;
    obs_t      obs [2];

    always #5 CLK = ~CLK;

    fb_write_scheduler_if bus0 ();
    fb_write_scheduler_if bus1 ();

    fb_write_scheduler #(.H_PIX(H), .V_PIX(V), .PIPE(1)) dut0 (
        .CLK(CLK), .RESET(RESET), .bus(bus0), .state_dbg(st0));
    fb_write_scheduler #(.H_PIX(H), .V_PIX(V), .PIPE(3)) dut1 (
        .CLK(CLK), .RESET(RESET), .bus(bus1), .state_dbg(st1));

    assign obs[0] = '{x: bus0.x_m, y: bus0.y_m, src: bus0.src, addr: bus0.addr_w,
                      wen: bus0.wen, snap: bus0.snap, busy: bus0.busy,
                      done: bus0.frame_done, st: st0};
    assign obs[1] = '{x: bus1.x_m, y: bus1.y_m, src: bus1.src, addr: bus1.addr_w,
                      wen: bus1.wen, snap: bus1.snap, busy: bus1.busy,
                      done: bus1.frame_done, st: st1};

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    int cyc = 0;
    int pipe_of [2] = '{1, 3};

    // Reference model: one job timeline per instance, anchored at its SNAP cycle.
    bit m_active [2] = '{1'b0, 1'b0};
    bit m_src    [2] = '{1'b0, 1'b0};
    bit m_pt     [2] = '{1'b0, 1'b0};
    bit m_pc     [2] = '{1'b0, 1'b0};
    bit m_fresh  [2] = '{1'b0, 1'b0};
    int m_s      [2] = '{0, 0};

    task automatic step(input bit tk, input bit cl, input bit hl, input bit rs);
        bus0.tick_req = tk; bus0.clear_req = cl; bus0.halt = hl;
        bus1.tick_req = tk; bus1.clear_req = cl; bus1.halt = hl;
        RESET = rs;
        @(posedge CLK);
        for (int d = 0; d < 2; d++) begin
            int p;
            bit idle, want_c, want_t;
            p = pipe_of[d];
            if (rs) begin
                m_active[d] = 1'b0; m_pt[d] = 1'b0; m_pc[d] = 1'b0; m_fresh[d] = 1'b1;
            end else begin
                m_fresh[d] = 1'b0;
                idle   = !m_active[d] || (cyc >= m_s[d] + N + p + 1);
                want_c = m_pc[d] | cl;
                want_t = m_pt[d] | tk;
                if (idle && want_c) begin
                    m_active[d] = 1'b1; m_s[d] = cyc + 1; m_src[d] = 1'b1;
                    m_pc[d] = 1'b0; m_pt[d] = want_t;
                end else if (idle && want_t && !hl) begin
                    m_active[d] = 1'b1; m_s[d] = cyc + 1; m_src[d] = 1'b0;
                    m_pt[d] = 1'b0; m_pc[d] = want_c;
                end else begin
                    m_pc[d] = want_c; m_pt[d] = want_t;
                end
            end
        end
        cyc++;
        @(negedge CLK);
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Per-cycle scoreboard against the model timeline.
    always @(negedge CLK) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                int p, t, ex, ey;
                bit in_job, e_snap, e_wen, e_done;
                fb_state_t e_st;
                p      = pipe_of[d];
                t      = cyc - m_s[d];
                in_job = m_active[d] && t >= 0 && t <= N + p;
                e_snap = in_job && t == 0 && !m_src[d];
                e_wen  = m_active[d] && t >= 1 + p && t <= N + p;
                e_done = m_active[d] && t == N + p + 1;
                e_st   = !in_job ? ST_IDLE : (t == 0) ? ST_SNAP : (t <= N) ? ST_SWEEP : ST_FLUSH;
                n_cmp += 5;
                if (obs[d].busy !== in_job) begin
                    n_bad++; $display("FAIL busy dut%0d cyc %0d: got %0d want %0d", d, cyc, obs[d].busy, in_job);
                end
                if (obs[d].snap !== e_snap) begin
                    n_bad++; $display("FAIL snap dut%0d cyc %0d: got %0d want %0d", d, cyc, obs[d].snap, e_snap);
                end
                if (obs[d].wen !== e_wen) begin
                    n_bad++; $display("FAIL wen dut%0d cyc %0d: got %0d want %0d", d, cyc, obs[d].wen, e_wen);
                end
                if (obs[d].done !== e_done) begin
                    n_bad++; $display("FAIL frame_done dut%0d cyc %0d: got %0d want %0d", d, cyc, obs[d].done, e_done);
                end
                if (obs[d].st !== e_st) begin
                    n_bad++; $display("FAIL state dut%0d cyc %0d: got %0d want %0d", d, cyc, obs[d].st, e_st);
                end
                if (e_wen) begin
                    n_cmp++;
                    if (obs[d].addr !== 19'(t - 1 - p)) begin
                        n_bad++; $display("FAIL addr_w dut%0d cyc %0d: got %0d want %0d", d, cyc, obs[d].addr, t - 1 - p);
                    end
                end
                if (in_job && t <= N) begin
                    ex = (t == 0) ? 0 : (t - 1) % H;
                    ey = (t == 0) ? 0 : (t - 1) / H;
                    n_cmp += 2;
                    if (obs[d].x !== 12'(ex) || obs[d].y !== 12'(ey)) begin
                        n_bad++; $display("FAIL coord dut%0d cyc %0d: got (%0d,%0d) want (%0d,%0d)", d, cyc, obs[d].x, obs[d].y, ex, ey);
                    end
                    if (obs[d].src !== m_src[d]) begin
                        n_bad++; $display("FAIL src dut%0d cyc %0d: got %0d want %0d", d, cyc, obs[d].src, m_src[d]);
                    end
                end
                if (m_fresh[d]) begin
                    n_cmp++;
                    if (obs[d].x !== '0 || obs[d].y !== '0 || obs[d].src !== 1'b0 || obs[d].addr !== '0) begin
                        n_bad++; $display("FAIL reset_outputs dut%0d cyc %0d: got %0h want 0", d, cyc, obs[d]);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        RESET = 1'b1;
        bus0.tick_req = 1'b0; bus0.clear_req = 1'b0; bus0.halt = 1'b0;
        bus1.tick_req = 1'b0; bus1.clear_req = 1'b0; bus1.halt = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (obs[d] !== '0) begin
                n_bad++; $display("FAIL reset_state dut%0d: got %0h want 0", d, obs[d]);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        int k;
        int snap_at [2], wen_first [2], wen_last [2], done_at [2], wen_cnt [2];
        int exp_wf [2], exp_wl [2], exp_done [2];
        idle_steps(2);
        k = cyc;
        for (int d = 0; d < 2; d++) begin
            snap_at[d] = -1; wen_first[d] = -1; wen_last[d] = -1; done_at[d] = -1; wen_cnt[d] = 0;
        end
        for (int i = 0; i < 23; i++) begin
            step(i == 0, 1'b0, 1'b0, 1'b0);
            for (int d = 0; d < 2; d++) begin
                if (obs[d].snap === 1'b1 && snap_at[d] < 0) snap_at[d] = cyc;
                if (obs[d].wen === 1'b1) begin
                    if (wen_first[d] < 0) wen_first[d] = cyc;
                    wen_last[d] = cyc;
                    wen_cnt[d]++;
                end
                if (obs[d].done === 1'b1 && done_at[d] < 0) done_at[d] = cyc;
            end
        end
        exp_wf   = '{k + 3, k + 5};
        exp_wl   = '{k + 14, k + 16};
        exp_done = '{k + 15, k + 17};
        for (int d = 0; d < 2; d++) begin
            n_cmp += 5;
            if (snap_at[d] != k + 1) begin
                n_bad++; $display("FAIL single_snap dut%0d: got %0d want %0d", d, snap_at[d] - k, 1);
            end
            if (wen_first[d] != exp_wf[d]) begin
                n_bad++; $display("FAIL single_wen_first dut%0d: got %0d want %0d", d, wen_first[d] - k, exp_wf[d] - k);
            end
            if (wen_last[d] != exp_wl[d]) begin
                n_bad++; $display("FAIL single_wen_last dut%0d: got %0d want %0d", d, wen_last[d] - k, exp_wl[d] - k);
            end
            if (done_at[d] != exp_done[d]) begin
                n_bad++; $display("FAIL single_done dut%0d: got %0d want %0d", d, done_at[d] - k, exp_done[d] - k);
            end
            if (wen_cnt[d] != N) begin
                n_bad++; $display("FAIL single_wen_count dut%0d: got %0d want %0d", d, wen_cnt[d], N);
            end
        end
    endtask

    task automatic test_both();
        int k, done1, snap1, src_first, src_second;
        k = cyc;
        done1 = -1; snap1 = -1; src_first = -1; src_second = -1;
        for (int i = 0; i < 40; i++) begin
            step(i == 0, i == 0, 1'b0, 1'b0);
            if (obs[0].done === 1'b1 && done1 < 0) done1 = cyc;
            if (obs[0].snap === 1'b1 && snap1 < 0) snap1 = cyc;
            if (cyc == k + 2) src_first = obs[0].src;
            if (cyc == k + 17) src_second = obs[0].src;
        end
        n_cmp += 4;
        if (done1 != k + 15) begin
            n_bad++; $display("FAIL both_first_done: got %0d want %0d", done1 - k, 15);
        end
        if (snap1 != k + 16) begin
            n_bad++; $display("FAIL both_render_snap: got %0d want %0d", snap1 - k, 16);
        end
        if (src_first != 1) begin
            n_bad++; $display("FAIL both_src_clear: got %0d want %0d", src_first, 1);
        end
        if (src_second != 0) begin
            n_bad++; $display("FAIL both_src_render: got %0d want %0d", src_second, 0);
        end
    endtask

    task automatic test_halt();
        int k, busy_cnt;
        k = cyc;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(i == 0, 1'b0, 1'b1, 1'b0);
            if (obs[0].busy !== 1'b0 || obs[1].busy !== 1'b0) busy_cnt++;
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp += 3;
        if (busy_cnt != 0) begin
            n_bad++; $display("FAIL halt_blocks: got %0d busy cycles want %0d", busy_cnt, 0);
        end
        for (int d = 0; d < 2; d++) begin
            if (obs[d].snap !== 1'b1) begin
                n_bad++; $display("FAIL halt_release_snap dut%0d cyc %0d: got %0d want %0d", d, cyc - k, obs[d].snap, 1);
            end
        end
        idle_steps(20);
    endtask

    task automatic test_coalesce();
        int wen_cnt [2], done_cnt [2];
        for (int d = 0; d < 2; d++) begin wen_cnt[d] = 0; done_cnt[d] = 0; end
        for (int i = 0; i < 50; i++) begin
            step(i == 0 || i == 3 || i == 6 || i == 9, 1'b0, 1'b0, 1'b0);
            for (int d = 0; d < 2; d++) begin
                if (obs[d].wen === 1'b1) wen_cnt[d]++;
                if (obs[d].done === 1'b1) done_cnt[d]++;
            end
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp += 2;
            if (wen_cnt[d] != 2 * N) begin
                n_bad++; $display("FAIL coalesce_wen dut%0d: got %0d want %0d", d, wen_cnt[d], 2 * N);
            end
            if (done_cnt[d] != 2) begin
                n_bad++; $display("FAIL coalesce_jobs dut%0d: got %0d want %0d", d, done_cnt[d], 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        for (int i = 0; i < 8; i++) step(i == 0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs[0].wen !== 1'b1) begin
            n_bad++; $display("FAIL reset_mid_pre_wen: got %0d want %0d", obs[0].wen, 1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            n_cmp += 2;
            if (obs[d].wen !== 1'b0) begin
                n_bad++; $display("FAIL reset_mid_wen dut%0d: got %0d want %0d", d, obs[d].wen, 0);
            end
            if (obs[d].busy !== 1'b0) begin
                n_bad++; $display("FAIL reset_mid_busy dut%0d: got %0d want %0d", d, obs[d].busy, 0);
            end
        end
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (obs[0].done === 1'b1 || obs[1].done === 1'b1) done_cnt++;
        end
        n_cmp++;
        if (done_cnt != 0) begin
            n_bad++; $display("FAIL reset_mid_done: got %0d pulses want %0d", done_cnt, 0);
        end
    endtask

    task automatic test_random();
        bit hl;
        hl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) hl = !hl;
            step($urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0, hl,
                 $urandom_range(0, 299) == 0);
        end
        idle_steps(45);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (obs[d].st !== ST_IDLE || obs[d].busy !== 1'b0) begin
                n_bad++; $display("FAIL random_drain dut%0d: got state %0d busy %0d want 0 0", d, obs[d].st, obs[d].busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_halt();
        test_coalesce();
        test_reset_mid();
        test_random();
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
